// File: rtl/mapper_reg_capture.sv
// mapper_reg_capture
//   Clocked front end for the cart mapper register file. Synchronises the
//   asynchronous Mega Drive bus strobes, glitch-filters LWR writes into the
//   $A130F0-$A130FF window and emits one valid/ready write beat per bus write.
//   After a console reset (vres) the power-on bank defaults are replayed.
// Ports
//   clk, rst            : system clock, async active-high reset
//   cart_address[8:1]   : bus address A8..A1 (async)
//   cart_data[7:0]      : bus data low byte (async)
//   lwr, tme, cas0, ce_0: bus strobes (async)
//   vres                : console reset, active-high (async)
//   wr_valid/wr_ready   : write beat handshake
//   wr_index, wr_data   : register index (0 = SRAM ctrl, 1..7 = bank) and payload
//   busy                : vres held or replay running
//   overrun_count       : saturating count of dropped bus writes
module mapper_reg_capture #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 3,
  parameter logic [4:0]  REG_BASE      = 5'h0F
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:1] cart_address,
  input  logic [7:0] cart_data,
  input  logic       lwr,
  input  logic       tme,
  input  logic       cas0,
  input  logic       ce_0,
  input  logic       vres,
  output logic       wr_valid,
  input  logic       wr_ready,
  output logic [2:0] wr_index,
  output logic [5:0] wr_data,
  output logic       busy,
  output logic [7:0] overrun_count
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FILTER    = 3'd1;
  localparam logic [2:0] S_HOLD      = 3'd2;
  localparam logic [2:0] S_VRES_HOLD = 3'd3;
  localparam logic [2:0] S_REPLAY    = 3'd4;

  localparam int unsigned CNT_W = (FILTER_CYCLES < 2) ? 1 : $clog2(FILTER_CYCLES + 1);
  // Bundle: {vres, ce_0, cas0, tme, lwr, data[5:0], addr[8:1]}; data[7:6] never used.
  localparam int unsigned SW = 19;
  localparam logic [SW-1:0] SYNC_RST = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 8'd0};

  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic [SW-1:0] sync_last;
  logic [8:1]    cart_address_s;
  logic [5:0]    cart_data_s;
  logic          lwr_s, tme_s, cas0_s, ce_0_s, vres_s;
  logic          qual;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       rep_q, rep_d;
  logic             wr_valid_q, wr_valid_d;
  logic [2:0]       wr_index_q, wr_index_d;
  logic [5:0]       wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic [7:0]       overrun_q, overrun_d;
  logic             accept, cap;
  logic [2:0]       cap_index;
  logic [5:0]       cap_data;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0],
              {vres, ce_0, cas0, tme, lwr, cart_data[5:0], cart_address}};
  end

  assign sync_last      = sync_q[SYNC_STAGES-1];
  assign cart_address_s = sync_last[7:0];
  assign cart_data_s    = sync_last[13:8];
  assign lwr_s          = sync_last[14];
  assign tme_s          = sync_last[15];
  assign cas0_s         = sync_last[16];
  assign ce_0_s         = sync_last[17];
  assign vres_s         = sync_last[18];

  assign qual = ~tme_s & cas0_s & ce_0_s & ~lwr_s & (cart_address_s[8:4] == REG_BASE);

  // Index 0 (SRAM control) only carries two payload bits.
  assign cap_index = cart_address_s[3:1];
  assign cap_data  = (cap_index == 3'd0) ? {4'b0, cart_data_s[1:0]} : cart_data_s;

  assign accept = wr_valid_q & wr_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rep_d      = rep_q;
    wr_valid_d = wr_valid_q & ~accept;
    wr_index_d = wr_index_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    overrun_d  = overrun_q;
    cap        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (qual) begin
          cnt_d = CNT_W'(1);
          if (FILTER_CYCLES == 1) begin
            cap     = 1'b1;
            state_d = S_HOLD;
          end else begin
            state_d = S_FILTER;
          end
        end
      end
      S_FILTER: begin
        if (!qual) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
          cnt_d   = '0;
          cap     = 1'b1;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (lwr_s || tme_s) state_d = S_IDLE;
      end
      S_VRES_HOLD: begin
        if (!vres_s) begin
          state_d    = S_REPLAY;
          rep_d      = 3'd0;
          wr_valid_d = 1'b1;
          wr_index_d = 3'd0;
          wr_data_d  = 6'd0;
        end
      end
      S_REPLAY: begin
        // Slot r defaults to bank r; slot 0 (SRAM control) defaults to 0.
        if (accept) begin
          if (rep_q == 3'd7) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            rep_d      = rep_q + 3'd1;
            wr_valid_d = 1'b1;
            wr_index_d = rep_q + 3'd1;
            wr_data_d  = {3'b0, rep_q + 3'd1};
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (cap) begin
      if (wr_valid_q && !accept) begin
        if (overrun_q != 8'hFF) overrun_d = overrun_q + 8'd1;
      end else begin
        wr_valid_d = 1'b1;
        wr_index_d = cap_index;
        wr_data_d  = cap_data;
      end
    end

    if (vres_s) begin
      state_d    = S_VRES_HOLD;
      cnt_d      = '0;
      wr_valid_d = 1'b0;
      busy_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= {SYNC_STAGES{SYNC_RST}};
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rep_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_index_q <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      overrun_q  <= '0;
    end else begin
      sync_q     <= sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rep_q      <= rep_d;
      wr_valid_q <= wr_valid_d;
      wr_index_q <= wr_index_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      overrun_q  <= overrun_d;
    end
  end

  assign wr_valid      = wr_valid_q;
  assign wr_index      = wr_index_q;
  assign wr_data       = wr_data_q;
  assign busy          = busy_q;
  assign overrun_count = overrun_q;

endmodule
